// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two W-bit operands four bits per clock through a carry register,
// with a valid/ready handshake on both the operand and result sides.
module nibble_serial_adder #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*WORDS-1:0]   a,
    input  logic [4*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);

    localparam int W    = 4 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SHW  = IDXW + 2;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);
    localparam logic [W-1:0]    NIB_MASK = W'(4'hF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [SHW-1:0]    shamt_s;
    logic [3:0]        a_nib_s;
    logic [3:0]        b_nib_s;
    logic [4:0]        nib_sum_s;
    logic              c_msb_s;
    logic              last_s;

    // Nibble slice adder for the current index
    always_comb begin
        shamt_s   = {idx_q, 2'b00};
        a_nib_s   = 4'(a_q >> shamt_s);
        b_nib_s   = 4'(b_q >> shamt_s);
        nib_sum_s = {1'b0, a_nib_s} + {1'b0, b_nib_s} + {4'b0000, carry_q};
        // carry into the top bit of this nibble, only meaningful on the last nibble
        c_msb_s   = a_nib_s[3] ^ b_nib_s[3] ^ nib_sum_s[3];
        last_s    = (idx_q == LAST_IDX);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= {IDXW{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            sum_q   <= {W{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture in IDLE, one nibble per edge in RUN, hold otherwise
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = {IDXW{1'b0}};
                    sum_d   = {W{1'b0}};
                end else begin
                    idx_d   = idx_q;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q & ~(NIB_MASK << shamt_s)) | (W'(nib_sum_s[3:0]) << shamt_s);
                carry_d = nib_sum_s[4];
                if (last_s) begin
                    cout_d = nib_sum_s[4];
                    ovf_d  = c_msb_s ^ nib_sum_s[4];
                    idx_d  = {IDXW{1'b0}};
                end else begin
                    idx_d  = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                idx_d = idx_q;
            end
            default: begin
                idx_d = {IDXW{1'b0}};
            end
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
        case (state_q)
            S_IDLE: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
            S_RUN: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b1;
            end
            S_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: transaction-level reference model checked every
// cycle, directed cases with hand-computed results, and a randomized handshake/reset phase.
module tb_nibble_serial_adder;

    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;
    logic           busy;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: 0 = waiting for operands, 1 = computing, 2 = result presented
    int             m_phase = 0;
    int             m_left  = 0;
    int             m_accepts = 0;
    logic [W-1:0]   m_sum = '0;
    logic           m_cout = 1'b0;
    logic           m_ovf = 1'b0;
    logic [W-1:0]   p_sum;
    logic           p_cout;
    logic           p_ovf;
    logic           prev_ov = 1'b0;
    int             rise_cyc[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [W:0]   full;
        logic [W-1:0] low;
        if (!rst_n) begin
            m_phase = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                low    = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, cin};
                p_sum  = full[W-1:0];
                p_cout = full[W];
                p_ovf  = low[W-1] ^ full[W];
                m_left = WORDS;
                m_phase = 1;
                m_accepts++;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = 2;
                m_sum   = p_sum;
                m_cout  = p_cout;
                m_ovf   = p_ovf;
            end
        end else begin
            if (out_ready) m_phase = 0;
        end
    endtask

    task automatic compare();
        chk("in_ready", {15'd0, in_ready}, {15'd0, (m_phase == 0)});
        chk("out_valid", {15'd0, out_valid}, {15'd0, (m_phase == 2)});
        chk("busy", {15'd0, busy}, {15'd0, (m_phase != 0)});
        if (m_phase != 1) begin
            chk("sum", sum, m_sum);
            chk("cout", {15'd0, cout}, {15'd0, m_cout});
            chk("ovf", {15'd0, ovf}, {15'd0, m_ovf});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare();
        if (out_valid && !prev_ov) rise_cyc.push_back(cyc);
        prev_ov = out_valid;
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", W'(lat), W'(WORDS));
        chk("lit_sum", sum, es);
        chk("lit_cout", {15'd0, cout}, {15'd0, ec});
        chk("lit_ovf", {15'd0, ovf}, {15'd0, eo});
        out_ready = 1'b1;
        step();
        chk("lit_in_ready_after_done", {15'd0, in_ready}, 16'd1);
        chk("lit_out_valid_after_done", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int n_rise;
        int acc0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        step();
        step();
        chk("lit_reset_in_ready", {15'd0, in_ready}, 16'd1);
        chk("lit_reset_sum", sum, 16'h0000);
        rst_n = 1'b1;
        step();

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        // the previous result stays visible while idle
        step();
        chk("lit_idle_hold_sum", sum, 16'h0000);
        chk("lit_idle_hold_cout", {15'd0, cout}, 16'd1);

        // Backpressure in DONE while new operands are offered
        a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) step();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            step();
            chk("lit_bp_sum", sum, 16'h8000);
            chk("lit_bp_ovf", {15'd0, ovf}, 16'd1);
            chk("lit_bp_in_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_rise = rise_cyc.size();
        step();
        chk("lit_bp_release_in_ready", {15'd0, in_ready}, 16'd1);
        for (int k = 0; k < 6; k++) step();
        chk("bp_no_second_result", W'(rise_cyc.size()), W'(n_rise));
        out_ready = 1'b0;

        // Reset in the middle of RUN
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0; in_valid = 1'b1;
        step();
        chk("lit_rst_run_sum", sum, 16'h0000);
        chk("lit_rst_run_in_ready", {15'd0, in_ready}, 16'd1);
        chk("lit_rst_run_busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        n_rise = rise_cyc.size();
        for (int k = 0; k < 8; k++) step();
        chk("rst_no_result", W'(rise_cyc.size()), W'(n_rise));
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-to-back with both handshakes held high
        rise_cyc.delete();
        acc0 = m_accepts;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            step();
            if (m_accepts - acc0 >= 3) in_valid = 1'b0;
        end
        chk("b2b_pulses", W'(rise_cyc.size()), W'(3));
        if (rise_cyc.size() == 3) begin
            for (int i = 1; i < 3; i++) chk("b2b_spacing", W'(rise_cyc[i] - rise_cyc[i-1]), W'(WORDS + 2));
        end

        // Randomized handshakes, operands and occasional resets
        for (int k = 0; k < 600; k++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                a = 16'hFFFF;
                b = W'($urandom_range(0, 1));
            end
            step();
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
